// File: rtl/mem_stream_reader.sv
// Read-side streaming master: reads a contiguous word range from a 0-latency memory
// into a 2-entry FIFO drained over valid/ready. Optional MEM_READER_STATS_EN adds a stall counter.
module mem_stream_reader #(
  parameter int WIDTH  = 16,
  parameter int HEIGHT = 128,
  parameter int LEN_W  = 8,
  localparam int AW    = $clog2(HEIGHT)
) (
  input  logic             clk,
  input  logic             arst_n_in,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [LEN_W-1:0] length,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    mem_read_addr,
  output logic             mem_read_en,
  input  logic [WIDTH-1:0] mem_qout,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      stall_cnt
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             pop, push;

  assign out_valid     = (cnt_q != 2'd0);
  assign out_data      = buf0_q;
  assign pop           = out_valid && out_ready;
  assign mem_read_addr = addr_q;
  assign mem_read_en   = push;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;

  // A pop in the same cycle frees a slot, so a full buffer can still accept a read.
  assign push = (state_q == READ) && (rem_q != '0) && ((cnt_q - {1'b0, pop}) < 2'd2);

  // buf0 is always the head; buf1 only holds the second entry when count is 2.
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    cnt_d  = cnt_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) buf0_d = mem_qout;
        else               buf1_d = mem_qout;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          buf0_d = mem_qout;
        end else begin
          buf0_d = buf1_q;
          buf1_d = mem_qout;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            addr_d  = base_addr;
            rem_d   = length;
            state_d = READ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      READ: begin
        if (push) begin
          addr_d = addr_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt_d == 2'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      buf0_q  <= '0;
      buf1_q  <= '0;
      cnt_q   <= 2'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

`ifdef MEM_READER_STATS_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((state_q == IDLE) && start)                            stall_d = '0;
    else if (out_valid && !out_ready && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) stall_q <= '0;
    else            stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
